// File: rtl/pwm_pkg.sv
// Shared register map and control-bit positions for the PWM generator slave.
package pwm_pkg;

   localparam logic [1:0] REG_DUTY   = 2'd0;
   localparam logic [1:0] REG_PERIOD = 2'd1;
   localparam logic [1:0] REG_PRESC  = 2'd2;
   localparam logic [1:0] REG_CTRL   = 2'd3;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_PEND = 1;

endpackage

// File: rtl/pwm_if.sv
// Avalon-MM bus between the PID controller's PWM master and the PWM generator slave.
interface pwm_if #(
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] avs_address;
   logic                  avs_write;
   logic [31:0]           avs_writedata;
   logic                  avs_read;
   logic [31:0]           avs_readdata;
   logic                  avs_readdatavalid;
   logic                  avs_waitrequest;

   modport slave (
      input  avs_address, avs_write, avs_writedata, avs_read,
      output avs_readdata, avs_readdatavalid, avs_waitrequest
   );

   modport master (
      output avs_address, avs_write, avs_writedata, avs_read,
      input  avs_readdata, avs_readdatavalid, avs_waitrequest
   );
endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus period counter; tick and boundary are combinational strobes for the current cycle.
module pwm_timebase #(
   parameter int CNT_WIDTH   = 12,
   parameter int PRESC_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [CNT_WIDTH-1:0]   period,
   input  logic [PRESC_WIDTH-1:0] prescale,
   output logic [CNT_WIDTH-1:0]   cnt,
   output logic                   tick,
   output logic                   boundary
);

   logic [PRESC_WIDTH-1:0] presc_cnt_r;
   logic [CNT_WIDTH-1:0]   cnt_r;

   // ">=" lets a period or prescale shrunk below the running count wrap on the next step
   assign tick     = enable && (presc_cnt_r >= prescale);
   assign boundary = tick && (cnt_r >= period);
   assign cnt      = cnt_r;

   // Prescaler and period counter, both parked at zero while disabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_cnt_r <= {PRESC_WIDTH{1'b0}};
         cnt_r       <= {CNT_WIDTH{1'b0}};
      end else if (!enable) begin
         presc_cnt_r <= {PRESC_WIDTH{1'b0}};
         cnt_r       <= {CNT_WIDTH{1'b0}};
      end else if (tick) begin
         presc_cnt_r <= {PRESC_WIDTH{1'b0}};
         if (boundary) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
         end else begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
         end
      end else begin
         presc_cnt_r <= presc_cnt_r + PRESC_WIDTH'(1);
      end
   end

endmodule

// File: rtl/pwm_generator.sv
// Avalon-MM PWM generator: double-buffered duty register applied on period boundaries,
// with waitrequest back-pressure on duty writes while an update is still pending.
module pwm_generator
   import pwm_pkg::*;
#(
   parameter int ADDR_WIDTH    = 16,
   parameter int CNT_WIDTH     = 12,
   parameter int PRESC_WIDTH   = 16,
   parameter int INIT_PERIOD   = 4095,
   parameter int INIT_PRESCALE = 0,
   parameter bit INIT_ENABLE   = 1'b1
) (
   input  logic  clk,
   input  logic  reset,
   pwm_if.slave  avs,
   output logic  pwm_out,
   output logic  period_tick
);

   logic [1:0]             addr_s;
   logic                   duty_wr_s;
   logic                   duty_acc_s;
   logic [CNT_WIDTH-1:0]   wdata_cnt_s;
   logic [31:0]            rd_mux_s;
   logic [CNT_WIDTH-1:0]   cnt_s;
   logic                   tick_s;
   logic                   boundary_s;
   logic                   unused_s;

   logic [CNT_WIDTH-1:0]   duty_shadow_r;
   logic [CNT_WIDTH-1:0]   duty_active_r;
   logic                   pending_r;
   logic [CNT_WIDTH-1:0]   period_r;
   logic [PRESC_WIDTH-1:0] prescale_r;
   logic                   enable_r;

   assign addr_s      = avs.avs_address[1:0];
   assign wdata_cnt_s = avs.avs_writedata[CNT_WIDTH-1:0];
   assign duty_wr_s   = avs.avs_write && (addr_s == REG_DUTY);
   assign duty_acc_s  = duty_wr_s && !pending_r;
   assign unused_s    = ^{avs.avs_address[ADDR_WIDTH-1:2], avs.avs_writedata[31:PRESC_WIDTH], tick_s};

   // Stall decided on the registered pending flag, so it never depends on this cycle's boundary
   assign avs.avs_waitrequest = duty_wr_s && pending_r;

   pwm_timebase #(
      .CNT_WIDTH   (CNT_WIDTH),
      .PRESC_WIDTH (PRESC_WIDTH)
   ) u_timebase (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable_r),
      .period   (period_r),
      .prescale (prescale_r),
      .cnt      (cnt_s),
      .tick     (tick_s),
      .boundary (boundary_s)
   );

   // Configuration registers that take effect immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         period_r   <= CNT_WIDTH'(INIT_PERIOD);
         prescale_r <= PRESC_WIDTH'(INIT_PRESCALE);
         enable_r   <= INIT_ENABLE;
      end else if (avs.avs_write) begin
         case (addr_s)
            REG_PERIOD: period_r   <= wdata_cnt_s;
            REG_PRESC:  prescale_r <= avs.avs_writedata[PRESC_WIDTH-1:0];
            REG_CTRL:   enable_r   <= avs.avs_writedata[CTRL_EN];
            default:    period_r   <= period_r;
         endcase
      end else begin
         period_r <= period_r;
      end
   end

   // Duty double buffer; while disabled the shadow flows straight through so nothing stalls
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         duty_shadow_r <= {CNT_WIDTH{1'b0}};
         duty_active_r <= {CNT_WIDTH{1'b0}};
         pending_r     <= 1'b0;
      end else if (!enable_r) begin
         pending_r     <= 1'b0;
         duty_active_r <= duty_shadow_r;
         if (duty_acc_s) begin
            duty_shadow_r <= wdata_cnt_s;
         end else begin
            duty_shadow_r <= duty_shadow_r;
         end
      end else if (boundary_s) begin
         pending_r <= 1'b0;
         if (duty_acc_s) begin
            duty_shadow_r <= wdata_cnt_s;
            duty_active_r <= wdata_cnt_s;
         end else begin
            duty_active_r <= duty_shadow_r;
         end
      end else if (duty_acc_s) begin
         duty_shadow_r <= wdata_cnt_s;
         pending_r     <= 1'b1;
      end else begin
         pending_r <= pending_r;
      end
   end

   // Output compare and boundary strobe, one cycle behind the counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm_out     <= 1'b0;
         period_tick <= 1'b0;
      end else begin
         pwm_out     <= enable_r && (cnt_s < duty_active_r);
         period_tick <= boundary_s;
      end
   end

   // Read-data selection from current register contents (old value on same-cycle write)
   always_comb begin
      rd_mux_s = 32'd0;
      case (addr_s)
         REG_DUTY:   rd_mux_s = {{(32-CNT_WIDTH){1'b0}}, duty_shadow_r};
         REG_PERIOD: rd_mux_s = {{(32-CNT_WIDTH){1'b0}}, period_r};
         REG_PRESC:  rd_mux_s = {{(32-PRESC_WIDTH){1'b0}}, prescale_r};
         REG_CTRL: begin
            rd_mux_s[CTRL_EN]   = enable_r;
            rd_mux_s[CTRL_PEND] = pending_r;
         end
         default:    rd_mux_s = 32'd0;
      endcase
   end

   // Registered read response
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avs.avs_readdata      <= 32'd0;
         avs.avs_readdatavalid <= 1'b0;
      end else begin
         avs.avs_readdatavalid <= avs.avs_read;
         if (avs.avs_read) begin
            avs.avs_readdata <= rd_mux_s;
         end else begin
            avs.avs_readdata <= avs.avs_readdata;
         end
      end
   end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: register vector table plus waveform-counting sequences.
module tb_pwm_generator;

   logic clk;
   logic reset;
   logic pwm_out;
   logic period_tick;
   int   total;
   int   bad;

   pwm_if #(.ADDR_WIDTH(16)) bus ();

   pwm_generator dut (
      .clk         (clk),
      .reset       (reset),
      .avs         (bus),
      .pwm_out     (pwm_out),
      .period_tick (period_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] waddr;
      logic [31:0] wdata;
      logic [15:0] raddr;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [31:0] d, output int waits);
      logic ws;
      bit   done;
      bus.avs_address   = a;
      bus.avs_writedata = d;
      bus.avs_write     = 1'b1;
      waits = 0;
      done  = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         ws = bus.avs_waitrequest;
         step();
         if (!ws) begin
            done = 1'b1;
            break;
         end
         waits++;
      end
      bus.avs_write = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL write_timeout: addr 0x%0h still stalled, required acceptance", a);
      end
   endtask

   task automatic rd_check(input string name, input logic [15:0] a, input logic [31:0] exp);
      bus.avs_address = a;
      bus.avs_read    = 1'b1;
      step();
      bus.avs_read = 1'b0;
      check({name, "_valid"}, {31'd0, bus.avs_readdatavalid}, 32'd1);
      check({name, "_data"}, bus.avs_readdata, exp);
   endtask

   task automatic wait_tick(input string name);
      int n;
      n = 0;
      while (period_tick !== 1'b1 && n < 20000) begin
         step();
         n++;
      end
      if (n >= 20000) begin
         total++;
         bad++;
         $display("FAIL %s_tick_timeout: period_tick never seen, required within 20000 cycles", name);
      end
   endtask

   // mode 0: wait for a period_tick first; mode 1: now is first sample of the period;
   // mode 2: now is the cycle just before the first sample
   task automatic measure(input string name, input int exp_high, input int p, input int mode);
      int high;
      int early;
      if (mode == 0) wait_tick(name);
      high  = 0;
      early = 0;
      for (int k = 1; k <= p; k++) begin
         if (!(mode == 1 && k == 1)) step();
         if (pwm_out === 1'b1) high++;
         if (k < p && period_tick === 1'b1) early++;
      end
      check({name, "_high"}, high, exp_high);
      check({name, "_early_tick"}, early, 32'd0);
      check({name, "_tick_at_end"}, {31'd0, period_tick}, 32'd1);
   endtask

   initial begin
      int w;
      int ticks;
      int highs;
      total = 0;
      bad   = 0;

      vecs[0] = '{16'h0003, 32'h0000_0000, 16'h0003, 32'h0000_0000};
      vecs[1] = '{16'h0000, 32'hFFF0_0123, 16'h0000, 32'h0000_0123};
      vecs[2] = '{16'h0001, 32'h0001_2345, 16'h0001, 32'h0000_0345};
      vecs[3] = '{16'h0002, 32'hABCD_1234, 16'h0002, 32'h0000_1234};
      vecs[4] = '{16'h0003, 32'hFFFF_FFFE, 16'h0003, 32'h0000_0000};
      vecs[5] = '{16'h0005, 32'h0000_0FFF, 16'h0001, 32'h0000_0FFF};
      vecs[6] = '{16'hFFFE, 32'h0000_0000, 16'h0002, 32'h0000_0000};
      vecs[7] = '{16'h0000, 32'h0000_0000, 16'h0000, 32'h0000_0000};
      vecs[8] = '{16'h0003, 32'h0000_0001, 16'h0003, 32'h0000_0001};

      reset             = 1'b1;
      bus.avs_address   = 16'd0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = 32'd0;
      bus.avs_read      = 1'b0;
      repeat (3) step();
      check("rst_pwm", {31'd0, pwm_out}, 32'd0);
      check("rst_tick", {31'd0, period_tick}, 32'd0);
      check("rst_rvalid", {31'd0, bus.avs_readdatavalid}, 32'd0);
      check("rst_rdata", bus.avs_readdata, 32'd0);
      reset = 1'b0;
      step();
      rd_check("rst_ctrl", 16'd3, 32'h1);
      step();
      check("rvalid_pulse", {31'd0, bus.avs_readdatavalid}, 32'd0);

      // register map vectors
      for (int i = 0; i < 9; i++) begin
         wr(vecs[i].waddr, vecs[i].wdata, w);
         check($sformatf("vec%0d_wait", i), w, 32'd0);
         rd_check($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp);
      end

      // simultaneous read and write returns the old value
      bus.avs_address   = 16'd1;
      bus.avs_writedata = 32'h0000_00AA;
      bus.avs_write     = 1'b1;
      bus.avs_read      = 1'b1;
      step();
      bus.avs_write = 1'b0;
      bus.avs_read  = 1'b0;
      check("rw_old_data", bus.avs_readdata, 32'h0000_0FFF);
      rd_check("rw_new", 16'd1, 32'h0000_00AA);
      wr(16'd1, 32'h0000_0FFF, w);

      measure("default", 0, 4096, 0);

      // duty 1024 on the default period
      wr(16'd0, 32'd1024, w);
      check("a_wait", w, 32'd0);
      measure("a_duty1024", 1024, 4096, 0);

      // back-to-back duty writes: the second stalls until just after the boundary
      wr(16'd0, 32'd100, w);
      check("b_first_wait", w, 32'd0);
      wr(16'd0, 32'd200, w);
      check("b_second_stalled", {31'd0, (w > 0)}, 32'd1);
      measure("b_duty100", 100, 4096, 1);
      measure("b_duty200", 200, 4096, 0);

      // prescale 1, period 3
      wr(16'd2, 32'd1, w);
      wr(16'd1, 32'd3, w);
      wr(16'd0, 32'd2, w);
      measure("c_duty2", 4, 8, 0);
      measure("c_duty2_rep", 4, 8, 0);
      wr(16'd0, 32'd0, w);
      measure("c_duty0", 0, 8, 0);
      wr(16'd0, 32'd4095, w);
      measure("c_duty4095", 8, 8, 0);

      // disable mid-period, update duty while disabled, re-enable
      wr(16'd3, 32'd0, w);
      step();
      check("d_pwm_low", {31'd0, pwm_out}, 32'd0);
      ticks = 0;
      highs = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (period_tick === 1'b1) ticks++;
         if (pwm_out === 1'b1) highs++;
      end
      check("d_no_ticks", ticks, 32'd0);
      check("d_no_high", highs, 32'd0);
      wr(16'd1, 32'd127, w);
      wr(16'd2, 32'd0, w);
      wr(16'd0, 32'd50, w);
      check("d_duty_wait", w, 32'd0);
      rd_check("d_ctrl", 16'd3, 32'h0);
      rd_check("d_duty", 16'd0, 32'd50);
      wr(16'd3, 32'd1, w);
      measure("d_reenable", 50, 128, 2);

      // reset during a stalled duty write
      wr(16'd0, 32'd10, w);
      check("e_first_wait", w, 32'd0);
      bus.avs_address   = 16'd0;
      bus.avs_writedata = 32'd20;
      bus.avs_write     = 1'b1;
      #1;
      check("e_stalled", {31'd0, bus.avs_waitrequest}, 32'd1);
      reset = 1'b1;
      #1;
      check("e_wait_drop", {31'd0, bus.avs_waitrequest}, 32'd0);
      check("e_pwm", {31'd0, pwm_out}, 32'd0);
      check("e_tick", {31'd0, period_tick}, 32'd0);
      step();
      step();
      bus.avs_write = 1'b0;
      reset = 1'b0;
      step();
      rd_check("e_duty", 16'd0, 32'd0);
      rd_check("e_period", 16'd1, 32'h0000_0FFF);
      rd_check("e_presc", 16'd2, 32'd0);
      rd_check("e_ctrl", 16'd3, 32'h1);
      measure("e_default", 0, 4096, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
